// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: divides each 8-clk cell into PF/MO/AL/CPU VRAM slots and grants pending 68k accesses.
// Defining VRAM_VBLANK_CPU_EN lets a pending CPU access take any slot while VBLANK_b is low.
module vram_slot_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       HSYNC,
   input  logic       VBLANK_b,
   input  logic       cpu_req,
   input  logic       cpu_wr,
   output logic [2:0] VRAC,
   output logic       VRAMRD_b,
   output logic       VRAMWR,
   output logic       NXL_b,
   output logic       PFL_b,
   output logic       cpu_ack
);
   logic [2:0] ph_q, ph_d;
   logic       pend_q, pend_d, wr_q, wr_d, grant_q, grant_d, hs_q, rs_q, rs_d, ack_q, ack_d;
   logic       acc, first, fin, rise, slot_ok;
`ifndef VRAM_VBLANK_CPU_EN
   logic       unused_vblank;
   assign unused_vblank = VBLANK_b;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         ph_q    <= '0;
         pend_q  <= 1'b0;
         wr_q    <= 1'b0;
         grant_q <= 1'b0;
         hs_q    <= 1'b0;
         rs_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         ph_q    <= ph_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         grant_q <= grant_d;
         hs_q    <= HSYNC;
         rs_q    <= rs_d;
         ack_q   <= ack_d;
      end
   end

   // A resync landing in a granted slot's first cycle is held so the access finishes both cycles.
   always_comb begin
      first   = grant_q & ~ph_q[0];
      fin     = grant_q & ph_q[0];
      acc     = cpu_req & ~pend_q & ~ack_q;
      rise    = HSYNC & ~hs_q;
      rs_d    = rise & first;
      ph_d    = ((rise & ~first) | rs_q) ? 3'd0 : ph_q + 3'd1;
`ifdef VRAM_VBLANK_CPU_EN
      slot_ok = ~ph_d[0] & ((ph_d == 3'd6) | ~VBLANK_b);
`else
      slot_ok = ph_d == 3'd6;
`endif
      grant_d = grant_q ? first : (pend_q | acc) & slot_ok;
      pend_d  = ~fin & (pend_q | acc);
      wr_d    = acc ? cpu_wr : wr_q;
      ack_d   = fin;
   end

   always_comb begin
      VRAC     = {grant_q & wr_q & ph_q[0], grant_q ? 2'b11 : ph_q[2:1]};
      VRAMRD_b = ~(grant_q & ~wr_q);
      VRAMWR   = grant_q & wr_q;
      PFL_b    = ~(~grant_q & (ph_q == 3'd1));
      NXL_b    = ~(~grant_q & (ph_q == 3'd3));
      cpu_ack  = ack_q;
   end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed cycle-by-cycle checks of slot map, grants, resync and reset.
module tb_vram_slot_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       HSYNC = 1'b0;
   logic       VBLANK_b = 1'b1;
   logic       cpu_req = 1'b0;
   logic       cpu_wr = 1'b0;
   logic [2:0] VRAC;
   logic       VRAMRD_b, VRAMWR, NXL_b, PFL_b, cpu_ack;
   logic [7:0] obs;
   int         checks = 0;
   int         failures = 0;

   vram_slot_arbiter dut (
      .clk(clk), .rst(rst), .HSYNC(HSYNC), .VBLANK_b(VBLANK_b), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
      .VRAC(VRAC), .VRAMRD_b(VRAMRD_b), .VRAMWR(VRAMWR), .NXL_b(NXL_b), .PFL_b(PFL_b), .cpu_ack(cpu_ack)
   );

   always #5 clk = ~clk;
   assign obs = {VRAC, VRAMRD_b, VRAMWR, NXL_b, PFL_b, cpu_ack};

   // {VRAC, VRAMRD_b, VRAMWR, NXL_b, PFL_b, cpu_ack} for a non-CPU-granted cycle at phase p
   function automatic logic [7:0] idle(input logic [2:0] p);
      return {1'b0, p[2:1], 1'b1, 1'b0, p != 3'd3, p != 3'd1, 1'b0};
   endfunction

   function automatic logic [7:0] cpu(input logic w, input logic s);
      return {w & s, 2'b11, w, w, 1'b1, 1'b1, 1'b0};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [7:0] e;
      rst = 1'b0;
      step();
      step();
      e = idle(3'd0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL reset got=%b exp=%b", obs, e); end
      rst = 1'b1;
      checks++;
      if (obs !== e) begin failures++; $display("FAIL first_after_reset got=%b exp=%b", obs, e); end
   endtask

   task automatic test_idle;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         e = idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL idle cyc=%0d got=%b exp=%b", i, obs, e); end
         step();
      end
   endtask

   task automatic test_write;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         e = i == 6 ? cpu(1'b1, 1'b0) : i == 7 ? cpu(1'b1, 1'b1) : i == 8 ? (idle(3'd0) | 8'd1) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL write cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 2) begin cpu_req = 1'b1; cpu_wr = 1'b1; end
         if (i == 9) cpu_req = 1'b0;
         step();
      end
   endtask

   task automatic test_read_late;
      logic [7:0] e;
      for (int i = 0; i < 24; i++) begin
         e = i == 14 ? cpu(1'b0, 1'b0) : i == 15 ? cpu(1'b0, 1'b1) : i == 16 ? (idle(3'd0) | 8'd1) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL read_late cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 6) begin cpu_req = 1'b1; cpu_wr = 1'b0; end
         if (i == 17) cpu_req = 1'b0;
         step();
      end
   endtask

   task automatic test_best_latency;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         e = i == 6 ? cpu(1'b0, 1'b0) : i == 7 ? cpu(1'b0, 1'b1) : i == 8 ? (idle(3'd0) | 8'd1) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL best_latency cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 5) begin cpu_req = 1'b1; cpu_wr = 1'b0; end
         if (i == 9) cpu_req = 1'b0;
         step();
      end
   endtask

   task automatic test_resync;
      logic [7:0] e;
      for (int i = 0; i < 20; i++) begin
         e = i == 6 ? cpu(1'b1, 1'b0) : i == 7 ? cpu(1'b1, 1'b1) : i == 8 ? (idle(3'd0) | 8'd1) :
             i >= 12 ? idle(3'(i - 12)) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL resync cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 2) begin cpu_req = 1'b1; cpu_wr = 1'b1; end
         if (i == 6 || i == 11) HSYNC = 1'b1;
         if (i == 9) begin cpu_req = 1'b0; HSYNC = 1'b0; end
         if (i == 13) HSYNC = 1'b0;
         step();
      end
   endtask

   task automatic test_resync_ack;
      logic [7:0] e;
      for (int i = 0; i < 17; i++) begin
         e = i == 6 ? cpu(1'b0, 1'b0) : i == 7 ? cpu(1'b0, 1'b1) : i == 8 ? (idle(3'd0) | 8'd1) :
             i >= 9 ? idle(3'(i - 9)) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL resync_ack cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 4) begin cpu_req = 1'b1; cpu_wr = 1'b0; end
         if (i == 8) HSYNC = 1'b1;
         if (i == 9) cpu_req = 1'b0;
         if (i == 10) HSYNC = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] e;
      for (int i = 0; i < 23; i++) begin
         e = i == 6 ? cpu(1'b1, 1'b0) : i >= 7 ? idle(3'(i - 7)) : idle(3'(i));
         checks++;
         if (obs !== e) begin failures++; $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 2) begin cpu_req = 1'b1; cpu_wr = 1'b1; end
         if (i == 6) begin rst = 1'b0; cpu_req = 1'b0; end
         if (i == 7) rst = 1'b1;
         step();
      end
   endtask

   task automatic test_vblank;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
`ifdef VRAM_VBLANK_CPU_EN
         e = i == 2 ? cpu(1'b0, 1'b0) : i == 3 ? cpu(1'b0, 1'b1) : i == 4 ? (idle(3'd4) | 8'd1) : idle(3'(i));
`else
         e = i == 6 ? cpu(1'b0, 1'b0) : i == 7 ? cpu(1'b0, 1'b1) : i == 8 ? (idle(3'd0) | 8'd1) : idle(3'(i));
`endif
         checks++;
         if (obs !== e) begin failures++; $display("FAIL vblank cyc=%0d got=%b exp=%b", i, obs, e); end
         if (i == 0) begin VBLANK_b = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; end
`ifdef VRAM_VBLANK_CPU_EN
         if (i == 5) cpu_req = 1'b0;
`else
         if (i == 9) cpu_req = 1'b0;
`endif
         step();
      end
      VBLANK_b = 1'b1;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_write();
      test_read_late();
      test_best_latency();
      test_resync();
      test_resync_ack();
      test_reset_mid();
      test_vblank();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
